// File: rtl/minbd_pkg.sv
// ============================================================================
// Module      : minbd_pkg
// Description : Shared flit layout, port indices and helpers for the MinBD
//               router ejection/injection stage and the downstream pdn.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package minbd_pkg;

    localparam int FLIT_W    = 11;
    localparam int BODY_W    = 7;
    localparam int NUM_PORTS = 4;

    localparam int VALID_B = 10;
    localparam int AGE_MSB = 9;
    localparam int AGE_LSB = 7;
    localparam int DX_MSB  = 6;
    localparam int DX_LSB  = 5;
    localparam int DY_MSB  = 4;
    localparam int DY_LSB  = 3;
    localparam int PL_MSB  = 2;
    localparam int PL_LSB  = 0;

    localparam logic [2:0] AGE_MAX = 3'd7;

    localparam int P_N = 0;
    localparam int P_S = 1;
    localparam int P_E = 2;
    localparam int P_W = 3;

    typedef logic [FLIT_W-1:0] flit_t;

    function automatic logic [2:0] age_inc(input logic [2:0] age);
        return (age == AGE_MAX) ? AGE_MAX : age + 3'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/minbd_inj_fifo.sv
// ============================================================================
// Module      : minbd_inj_fifo
// Description : Synchronous power-of-two FIFO holding local injection flits.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module minbd_inj_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [AW:0] C_DEPTH = DEPTH[AW:0];

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             w_push;
    logic             w_pop;

    assign full_o  = (count_q == C_DEPTH);
    assign empty_o = (count_q == '0);
    assign dout_o  = mem_q[rd_ptr_q];

    // Full refuses a push even when a pop happens on the same edge.
    assign w_push = push_i && !full_o;
    assign w_pop  = pop_i && !empty_o;

    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (w_push && !w_pop) begin
                count_q <= count_q + CW'(1);
            end else if (w_pop && !w_push) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/minbd_ej_inj.sv
// ============================================================================
// Module      : minbd_ej_inj
// Description : MinBD ejection/injection stage: ejects one local flit, ages
//               the rest and injects one FIFO flit into a free link slot.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module minbd_ej_inj
    import minbd_pkg::*;
#(
    parameter logic [1:0]  MY_X         = 2'd1,
    parameter logic [1:0]  MY_Y         = 2'd2,
    parameter int unsigned INJ_DEPTH    = 4,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [FLIT_W-1:0] north_in,
    input  logic [FLIT_W-1:0] south_in,
    input  logic [FLIT_W-1:0] east_in,
    input  logic [FLIT_W-1:0] west_in,
    output logic [FLIT_W-1:0] north_out,
    output logic [FLIT_W-1:0] south_out,
    output logic [FLIT_W-1:0] east_out,
    output logic [FLIT_W-1:0] west_out,
    input  logic [BODY_W-1:0] inj_flit,
    input  logic              inj_valid,
    output logic              inj_ready,
    output logic              ej_valid,
    output logic [FLIT_W-1:0] ej_flit,
    output logic              starve
);

    localparam logic [7:0] C_STARVE_LIM = 8'(STARVE_LIMIT);

    flit_t             w_in   [NUM_PORTS];
    flit_t             out_d  [NUM_PORTS];
    flit_t             out_q  [NUM_PORTS];
    logic              ej_hit;
    logic [1:0]        ej_idx;
    logic [2:0]        ej_age;
    flit_t             ej_flit_d;
    flit_t             ej_flit_q;
    logic              ej_valid_q;
    logic              inj_do;
    logic              fifo_full;
    logic              fifo_empty;
    logic [BODY_W-1:0] fifo_head;
    logic [7:0]        starve_cnt_d;
    logic [7:0]        starve_cnt_q;
    logic              starve_q;

    minbd_inj_fifo #(
        .DEPTH (INJ_DEPTH),
        .WIDTH (BODY_W)
    ) u_inj_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (inj_valid),
        .din_i   (inj_flit),
        .pop_i   (inj_do),
        .dout_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        w_in[P_N] = north_in;
        w_in[P_S] = south_in;
        w_in[P_E] = east_in;
        w_in[P_W] = west_in;

        // Strict '>' keeps the lower port index on an age tie (N > S > E > W).
        ej_hit = 1'b0;
        ej_idx = 2'd0;
        ej_age = 3'd0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (w_in[p][VALID_B] &&
                (w_in[p][DX_MSB:DX_LSB] == MY_X) &&
                (w_in[p][DY_MSB:DY_LSB] == MY_Y) &&
                (!ej_hit || (w_in[p][AGE_MSB:AGE_LSB] > ej_age))) begin
                ej_hit = 1'b1;
                ej_idx = 2'(p);
                ej_age = w_in[p][AGE_MSB:AGE_LSB];
            end
        end
        ej_flit_d = ej_hit ? w_in[ej_idx] : '0;

        inj_do = 1'b0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (!w_in[p][VALID_B] || (ej_hit && (ej_idx == 2'(p)))) begin
                out_d[p] = '0;
            end else begin
                out_d[p] = {1'b1, age_inc(w_in[p][AGE_MSB:AGE_LSB]),
                            w_in[p][DX_MSB:PL_LSB]};
            end
            if (!fifo_empty && !inj_do && !out_d[p][VALID_B]) begin
                out_d[p] = {1'b1, 3'b000, fifo_head};
                inj_do   = 1'b1;
            end
        end

        if (fifo_empty || inj_do) begin
            starve_cnt_d = '0;
        end else if (starve_cnt_q != C_STARVE_LIM) begin
            starve_cnt_d = starve_cnt_q + 8'd1;
        end else begin
            starve_cnt_d = starve_cnt_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                out_q[p] <= '0;
            end
            ej_valid_q   <= 1'b0;
            ej_flit_q    <= '0;
            starve_cnt_q <= '0;
            starve_q     <= 1'b0;
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                out_q[p] <= out_d[p];
            end
            ej_valid_q   <= ej_hit;
            ej_flit_q    <= ej_flit_d;
            starve_cnt_q <= starve_cnt_d;
            starve_q     <= (starve_cnt_d == C_STARVE_LIM);
        end
    end

    assign north_out = out_q[P_N];
    assign south_out = out_q[P_S];
    assign east_out  = out_q[P_E];
    assign west_out  = out_q[P_W];
    assign ej_valid  = ej_valid_q;
    assign ej_flit   = ej_flit_q;
    assign starve    = starve_q;
    assign inj_ready = !fifo_full;

endmodule

`default_nettype wire

// File: tb/tb_minbd_ej_inj.sv
// ============================================================================
// Module      : tb_minbd_ej_inj
// Description : Self-checking bench for minbd_ej_inj: directed vector table,
//               hand sequences and randomized traffic against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_minbd_ej_inj;

    localparam logic [1:0] TB_X    = 2'd1;
    localparam logic [1:0] TB_Y    = 2'd2;
    localparam int         DEPTH   = 4;
    localparam int         SLIMIT  = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] tin [4];
    logic        iv = 1'b0;
    logic [6:0]  ifl = '0;
    logic [10:0] n_o, s_o, e_o, w_o, ej_f;
    logic        ejv, rdy, stv;

    int checks = 0;
    int failures = 0;

    // Reference model state
    logic [6:0]  mq[$];
    int          mcnt = 0;
    logic [10:0] e_out [4];
    logic        e_ejv;
    logic [10:0] e_ej;
    logic        e_rdy;
    logic        e_starve;

    typedef struct {
        logic [10:0] n, s, e, w;
        logic        iv;
        logic [6:0]  ifl;
        logic [10:0] xn, xs, xe, xw;
        logic        xejv;
        logic [10:0] xej;
    } vec_t;
    vec_t vt [8];

    minbd_ej_inj #(
        .MY_X         (TB_X),
        .MY_Y         (TB_Y),
        .INJ_DEPTH    (DEPTH),
        .STARVE_LIMIT (SLIMIT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .north_in  (tin[0]),
        .south_in  (tin[1]),
        .east_in   (tin[2]),
        .west_in   (tin[3]),
        .north_out (n_o),
        .south_out (s_o),
        .east_out  (e_o),
        .west_out  (w_o),
        .inj_flit  (ifl),
        .inj_valid (iv),
        .inj_ready (rdy),
        .ej_valid  (ejv),
        .ej_flit   (ej_f),
        .starve    (stv)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [10:0] act, input logic [10:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // One clock edge of the router, derived from the behavioural rules.
    task automatic model_edge();
        int          ej;
        bit          inj;
        bit          push_ok;
        logic [2:0]  a;
        ej = -1;
        for (int p = 0; p < 4; p++) begin
            if (tin[p][10] && tin[p][6:5] == TB_X && tin[p][4:3] == TB_Y) begin
                if (ej < 0 || tin[p][9:7] > tin[ej][9:7]) ej = p;
            end
        end
        e_ejv = (ej >= 0);
        e_ej  = (ej >= 0) ? tin[ej] : 11'd0;
        for (int p = 0; p < 4; p++) begin
            if (!tin[p][10] || p == ej) begin
                e_out[p] = 11'd0;
            end else begin
                a = tin[p][9:7];
                a = (a == 3'd7) ? 3'd7 : a + 3'd1;
                e_out[p] = {1'b1, a, tin[p][6:0]};
            end
        end
        push_ok = iv && (mq.size() < DEPTH);
        inj = 0;
        if (mq.size() > 0) begin
            for (int p = 0; p < 4; p++) begin
                if (!inj && !e_out[p][10]) begin
                    e_out[p] = {4'b1000, mq[0]};
                    inj = 1;
                end
            end
        end
        if (mq.size() == 0 || inj) mcnt = 0;
        else if (mcnt < SLIMIT) mcnt++;
        if (inj) void'(mq.pop_front());
        if (push_ok) mq.push_back(ifl);
        e_rdy    = (mq.size() < DEPTH);
        e_starve = (mcnt == SLIMIT);
    endtask

    task automatic cmp_model();
        chk("north_out", n_o, e_out[0]);
        chk("south_out", s_o, e_out[1]);
        chk("east_out",  e_o, e_out[2]);
        chk("west_out",  w_o, e_out[3]);
        chk("ej_valid",  11'(ejv), 11'(e_ejv));
        chk("ej_flit",   ej_f, e_ej);
        chk("inj_ready", 11'(rdy), 11'(e_rdy));
        chk("starve",    11'(stv), 11'(e_starve));
    endtask

    task automatic tick(input bit use_model);
        @(posedge clk);
        model_edge();
        #1;
        if (use_model) cmp_model();
    endtask

    function automatic logic [10:0] rnd_flit(input int vthresh);
        logic [10:0] f;
        if ($urandom_range(0, 9) < vthresh) begin
            f[10]  = 1'b1;
            f[9:7] = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) begin
                f[6:5] = TB_X;
                f[4:3] = TB_Y;
            end else begin
                f[6:3] = 4'($urandom);
            end
            f[2:0] = 3'($urandom);
        end else begin
            f = {1'b0, 10'($urandom)};
        end
        return f;
    endfunction

    initial begin
        for (int p = 0; p < 4; p++) tin[p] = '0;

        vt[0] = '{11'b10100110101, 11'b10110000011, 11'd0, 11'd0, 1'b0, 7'd0,
                  11'd0, 11'b11000000011, 11'd0, 11'd0, 1'b1, 11'b10100110101};
        vt[1] = '{11'd0, 11'd0, 11'b11010110001, 11'b11010110010, 1'b0, 7'd0,
                  11'd0, 11'd0, 11'd0, 11'b11100110010, 1'b1, 11'b11010110001};
        vt[2] = '{11'b10010110000, 11'd0, 11'd0, 11'b11100110111, 1'b0, 7'd0,
                  11'b10100110000, 11'd0, 11'd0, 11'd0, 1'b1, 11'b11100110111};
        vt[3] = '{11'b11111111111, 11'b01010110101, 11'b10000000000, 11'd0, 1'b0, 7'd0,
                  11'b11111111111, 11'd0, 11'b10010000000, 11'd0, 1'b0, 11'd0};
        vt[4] = '{11'b10110110001, 11'b10110110010, 11'd0, 11'd0, 1'b0, 7'd0,
                  11'd0, 11'b11000110010, 11'd0, 11'd0, 1'b1, 11'b10110110001};
        vt[5] = '{11'd0, 11'd0, 11'd0, 11'd0, 1'b1, 7'b0010110,
                  11'd0, 11'd0, 11'd0, 11'd0, 1'b0, 11'd0};
        vt[6] = '{11'd0, 11'd0, 11'd0, 11'd0, 1'b0, 7'd0,
                  11'b10000010110, 11'd0, 11'd0, 11'd0, 1'b0, 11'd0};
        vt[7] = '{11'd0, 11'd0, 11'd0, 11'd0, 1'b0, 7'd0,
                  11'd0, 11'd0, 11'd0, 11'd0, 1'b0, 11'd0};

        // Reset held, then released with no traffic
        repeat (3) @(posedge clk);
        #1;
        chk("rst_north", n_o, 11'd0);
        chk("rst_ej_valid", 11'(ejv), 11'd0);
        chk("rst_inj_ready", 11'(rdy), 11'd1);
        chk("rst_starve", 11'(stv), 11'd0);
        rst_n = 1'b1;
        tick(1);

        // Directed vector table
        for (int i = 0; i < 8; i++) begin
            tin[0] = vt[i].n; tin[1] = vt[i].s; tin[2] = vt[i].e; tin[3] = vt[i].w;
            iv = vt[i].iv; ifl = vt[i].ifl;
            tick(0);
            chk($sformatf("vec%0d_north", i), n_o, vt[i].xn);
            chk($sformatf("vec%0d_south", i), s_o, vt[i].xs);
            chk($sformatf("vec%0d_east", i),  e_o, vt[i].xe);
            chk($sformatf("vec%0d_west", i),  w_o, vt[i].xw);
            chk($sformatf("vec%0d_ejv", i),   11'(ejv), 11'(vt[i].xejv));
            chk($sformatf("vec%0d_ejf", i),   ej_f, vt[i].xej);
        end
        chk("vec_inj_ready", 11'(rdy), 11'd1);
        iv = 1'b0;

        // Full links: fill FIFO, refuse 5th push, starve, then inject on west
        for (int p = 0; p < 4; p++) tin[p] = {1'b1, 3'(p), 4'b0000, 3'(p)};
        for (int i = 0; i < 4; i++) begin
            iv = 1'b1; ifl = 7'(i * 9 + 3);
            tick(1);
        end
        chk("full_inj_ready", 11'(rdy), 11'd0);
        ifl = 7'h7F;
        tick(1);
        iv = 1'b0;
        repeat (3) tick(1);
        chk("starve_pre", 11'(stv), 11'd0);
        tick(1);
        chk("starve_set", 11'(stv), 11'd1);
        tin[3] = '0;
        tick(1);
        chk("inj_west", w_o, {4'b1000, 7'd3});
        chk("starve_clr", 11'(stv), 11'd0);
        chk("ready_back", 11'(rdy), 11'd1);
        tin[3] = {1'b1, 3'd3, 4'b0000, 3'd3};
        tick(1);

        // Asynchronous reset mid-operation with 3 flits queued
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_north", n_o, 11'd0);
        chk("arst_south", s_o, 11'd0);
        chk("arst_east",  e_o, 11'd0);
        chk("arst_west",  w_o, 11'd0);
        chk("arst_ready", 11'(rdy), 11'd1);
        chk("arst_starve", 11'(stv), 11'd0);
        mq.delete();
        mcnt = 0;
        for (int p = 0; p < 4; p++) tin[p] = '0;
        #3;
        rst_n = 1'b1;
        tick(1);
        tick(1);
        chk("post_rst_no_inj", n_o, 11'd0);

        // Randomized traffic against the reference model
        for (int c = 0; c < 600; c++) begin
            int vth;
            vth = ((c / 40) % 2 == 1) ? 10 : 5;
            for (int p = 0; p < 4; p++) tin[p] = rnd_flit(vth);
            iv  = ($urandom_range(0, 2) != 0);
            ifl = 7'($urandom);
            tick(1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
